// File: rtl/mem_io_responder.sv
// mem_io_responder: memory-side responder for the CPU byte bus.
// Holds the program/data RAM, the I/O page at 0x30000-0x30007 (UART TX FIFO,
// cycle counter with snapshot latch, halt flag) and io_buffer_full back-pressure.
// Optional feature: define IO_RX_EN to build the RX FIFO and the rx_* ports.
module mem_io_responder #(
  parameter int ADDR_WIDTH     = 17,
  parameter int TX_DEPTH       = 16,
  parameter int TX_FULL_MARGIN = 2,
  parameter int RX_DEPTH       = 8
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] mem_a,
  input  logic [7:0]  mem_dout,
  input  logic        mem_wr,
  output logic [7:0]  mem_din,
  output logic        io_buffer_full,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
`ifdef IO_RX_EN
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
`endif
  output logic        program_halt,
  output logic        tx_overflow
);

  localparam int TX_PW = $clog2(TX_DEPTH);
  localparam int TX_CW = TX_PW + 1;
  localparam logic [TX_CW-1:0] TX_FULL_COUNT = TX_CW'(TX_DEPTH);
  localparam logic [TX_CW-1:0] TX_MARGIN     = TX_CW'(TX_FULL_MARGIN);

  // Bus decode
  logic                  is_io;
  logic [2:0]            io_off;
  logic [ADDR_WIDTH-1:0] ram_idx;
  logic                  wr_ok;
  logic                  ram_we;
  logic                  ram_re;
  logic                  io_re;
  logic                  unused_mem_a;

  // Read return path: rd_sel_q picks RAM output (1) or I/O read register (0)
  logic [7:0] ram [0:(1<<ADDR_WIDTH)-1];
  logic [7:0] ram_rdata;
  logic [7:0] io_rdata;
  logic [7:0] io_rdata_q, io_rdata_d;
  logic       rd_sel_q, rd_sel_d;

  // Control / status
  logic        halt_q, halt_d;
  logic        tx_overflow_q, tx_overflow_d;
  logic        io_buffer_full_q, io_buffer_full_d;
  logic [31:0] counter_q, counter_d;
  logic [23:0] snap_q, snap_d;

  // TX FIFO
  logic [7:0]       tx_mem [0:TX_DEPTH-1];
  logic [TX_PW-1:0] tx_wr_ptr_q, tx_wr_ptr_d;
  logic [TX_PW-1:0] tx_rd_ptr_q, tx_rd_ptr_d;
  logic [TX_CW-1:0] tx_count_q, tx_count_d;
  logic             tx_push_req;
  logic             tx_push;
  logic             tx_pop;
  logic             tx_full;
  logic [7:0]       tx_push_data;

`ifdef IO_RX_EN
  localparam int RX_PW = $clog2(RX_DEPTH);
  localparam int RX_CW = RX_PW + 1;
  localparam logic [RX_CW-1:0] RX_FULL_COUNT = RX_CW'(RX_DEPTH);

  logic [7:0]       rx_mem [0:RX_DEPTH-1];
  logic [RX_PW-1:0] rx_wr_ptr_q, rx_wr_ptr_d;
  logic [RX_PW-1:0] rx_rd_ptr_q, rx_rd_ptr_d;
  logic [RX_CW-1:0] rx_count_q, rx_count_d;
  logic             rx_push;
  logic             rx_pop;
`endif

  assign is_io        = (mem_a[17:16] == 2'b11);
  assign io_off       = mem_a[2:0];
  assign ram_idx      = mem_a[ADDR_WIDTH-1:0];
  assign wr_ok        = mem_wr && !halt_q && rst_in;
  assign ram_we       = wr_ok && !is_io;
  assign ram_re       = !mem_wr && !is_io;
  assign io_re        = !mem_wr && is_io;
  assign unused_mem_a = ^mem_a[31:18];

  assign mem_din        = rd_sel_q ? ram_rdata : io_rdata_q;
  assign tx_valid       = (tx_count_q != '0);
  assign tx_data        = tx_mem[tx_rd_ptr_q];
  assign io_buffer_full = io_buffer_full_q;
  assign program_halt   = halt_q;
  assign tx_overflow    = tx_overflow_q;

  // RAM: stores land at the edge, loads are registered so the next cycle sees them
  always_ff @(posedge clk_in) begin
    if (ram_we) ram[ram_idx] <= mem_dout;
    if (ram_re) ram_rdata <= ram[ram_idx];
  end

  // TX FIFO: push on data writes to offset 0 and on the halt write (which sends 0x00)
  always_comb begin
    tx_push_req  = wr_ok && is_io &&
                   (((io_off == 3'd0) && (mem_dout != 8'h00)) || (io_off == 3'd4));
    tx_push_data = (io_off == 3'd4) ? 8'h00 : mem_dout;
    tx_pop       = tx_valid && tx_ready;
    tx_full      = (tx_count_q == TX_FULL_COUNT);
    tx_push      = tx_push_req && (!tx_full || tx_pop);
    tx_wr_ptr_d  = tx_wr_ptr_q;
    tx_rd_ptr_d  = tx_rd_ptr_q;
    tx_count_d   = tx_count_q;
    if (tx_push) tx_wr_ptr_d = tx_wr_ptr_q + TX_PW'(1);
    if (tx_pop)  tx_rd_ptr_d = tx_rd_ptr_q + TX_PW'(1);
    if (tx_push && !tx_pop) tx_count_d = tx_count_q + TX_CW'(1);
    else if (!tx_push && tx_pop) tx_count_d = tx_count_q - TX_CW'(1);
    tx_overflow_d    = tx_overflow_q || (tx_push_req && tx_full && !tx_pop);
    io_buffer_full_d = ((TX_FULL_COUNT - tx_count_d) <= TX_MARGIN);
    halt_d           = halt_q || (wr_ok && is_io && (io_off == 3'd4));
    counter_d        = counter_q + 32'd1;
  end

  // TX FIFO storage
  always_ff @(posedge clk_in) begin
    if (tx_push) tx_mem[tx_wr_ptr_q] <= tx_push_data;
  end

`ifdef IO_RX_EN
  assign rx_ready = (rx_count_q != RX_FULL_COUNT);

  // RX FIFO pointers and occupancy; pops come from 0x30000 reads
  always_comb begin
    rx_push     = rx_valid && rx_ready;
    rx_wr_ptr_d = rx_wr_ptr_q;
    rx_rd_ptr_d = rx_rd_ptr_q;
    rx_count_d  = rx_count_q;
    if (rx_push) rx_wr_ptr_d = rx_wr_ptr_q + RX_PW'(1);
    if (rx_pop)  rx_rd_ptr_d = rx_rd_ptr_q + RX_PW'(1);
    if (rx_push && !rx_pop) rx_count_d = rx_count_q + RX_CW'(1);
    else if (!rx_push && rx_pop) rx_count_d = rx_count_q - RX_CW'(1);
  end

  // RX FIFO storage
  always_ff @(posedge clk_in) begin
    if (rx_push) rx_mem[rx_wr_ptr_q] <= rx_data;
  end

  // RX FIFO state registers
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      rx_wr_ptr_q <= '0;
      rx_rd_ptr_q <= '0;
      rx_count_q  <= '0;
    end else begin
      rx_wr_ptr_q <= rx_wr_ptr_d;
      rx_rd_ptr_q <= rx_rd_ptr_d;
      rx_count_q  <= rx_count_d;
    end
  end
`endif

  // I/O read mux, snapshot capture and read-source select
  always_comb begin
    io_rdata = 8'h00;
    snap_d   = snap_q;
`ifdef IO_RX_EN
    rx_pop   = 1'b0;
`endif
    case (io_off)
      3'd0: begin
`ifdef IO_RX_EN
        if (rx_count_q != '0) begin
          io_rdata = rx_mem[rx_rd_ptr_q];
          rx_pop   = io_re;
        end
`endif
      end
      3'd4: begin
        io_rdata = counter_q[7:0];
        if (io_re) snap_d = counter_q[31:8];
      end
      3'd5:    io_rdata = snap_q[7:0];
      3'd6:    io_rdata = snap_q[15:8];
      3'd7:    io_rdata = snap_q[23:16];
      default: io_rdata = 8'h00;
    endcase
    io_rdata_d = io_re ? io_rdata : io_rdata_q;
    rd_sel_d   = ram_re ? 1'b1 : (io_re ? 1'b0 : rd_sel_q);
  end

  // Main state registers; reset drops FIFO contents and any pending read data
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      io_rdata_q       <= 8'h00;
      rd_sel_q         <= 1'b0;
      halt_q           <= 1'b0;
      tx_overflow_q    <= 1'b0;
      io_buffer_full_q <= 1'b0;
      counter_q        <= 32'd0;
      snap_q           <= 24'd0;
      tx_wr_ptr_q      <= '0;
      tx_rd_ptr_q      <= '0;
      tx_count_q       <= '0;
    end else begin
      io_rdata_q       <= io_rdata_d;
      rd_sel_q         <= rd_sel_d;
      halt_q           <= halt_d;
      tx_overflow_q    <= tx_overflow_d;
      io_buffer_full_q <= io_buffer_full_d;
      counter_q        <= counter_d;
      snap_q           <= snap_d;
      tx_wr_ptr_q      <= tx_wr_ptr_d;
      tx_rd_ptr_q      <= tx_rd_ptr_d;
      tx_count_q       <= tx_count_d;
    end
  end

endmodule

// File: tb/tb_mem_io_responder.sv
// tb_mem_io_responder: directed steps with randomized data and addresses,
// checked against a queue/array reference model of mem_io_responder.
// Define IO_RX_EN to include the RX FIFO steps.
module tb_mem_io_responder;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [31:0] mem_a;
  logic [7:0]  mem_dout;
  logic        mem_wr;
  logic [7:0]  mem_din;
  logic        io_buffer_full;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        program_halt;
  logic        tx_overflow;
`ifdef IO_RX_EN
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
`endif

  int checks = 0;
  int failures = 0;

  // Reference model state
  logic [7:0]  ram_m [int unsigned];
  logic [7:0]  txq [$];
  logic [7:0]  rxq [$];
  logic [31:0] cyc;
  logic [23:0] snap_m;
  logic        halt_m;
  logic        ovf_m;
  logic [7:0]  exp_din;
  bit          din_known;

  mem_io_responder dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .mem_a          (mem_a),
    .mem_dout       (mem_dout),
    .mem_wr         (mem_wr),
    .mem_din        (mem_din),
    .io_buffer_full (io_buffer_full),
    .tx_data        (tx_data),
    .tx_valid       (tx_valid),
    .tx_ready       (tx_ready),
`ifdef IO_RX_EN
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .rx_ready       (rx_ready),
`endif
    .program_halt   (program_halt),
    .tx_overflow    (tx_overflow)
  );

  // 10-unit clock
  always #5 clk_in = ~clk_in;

  // One comparison of a DUT output against a model/constant expectation
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Compare every observable output against the model after an edge
  task automatic checkAll(input string tag);
    if (din_known) checkOutput({tag, "/mem_din"}, mem_din, exp_din);
    checkOutput({tag, "/tx_valid"}, tx_valid, txq.size() != 0);
    checkOutput({tag, "/io_buffer_full"}, io_buffer_full, (16 - txq.size()) <= 2);
    checkOutput({tag, "/program_halt"}, program_halt, halt_m);
    checkOutput({tag, "/tx_overflow"}, tx_overflow, ovf_m);
    if (txq.size() != 0) checkOutput({tag, "/tx_data"}, tx_data, txq[0]);
`ifdef IO_RX_EN
    checkOutput({tag, "/rx_ready"}, rx_ready, rxq.size() < 8);
`endif
  endtask

  // Advance the reference model by one clock edge using the current inputs
  task automatic modelEdge();
    logic        io;
    logic [2:0]  off;
    int unsigned idx;
    logic [31:0] pre;
    bit          pop_tx;
`ifdef IO_RX_EN
    bit          rx_ok;
`endif
    if (!rst_in) begin
      txq.delete();
      rxq.delete();
      cyc = 0;
      snap_m = 0;
      halt_m = 0;
      ovf_m = 0;
      exp_din = 8'h00;
      din_known = 1;
    end else begin
      io = (mem_a[17:16] == 2'b11);
      off = mem_a[2:0];
      idx = mem_a & 32'h1FFFF;
      pre = cyc;
      cyc = cyc + 1;
      pop_tx = tx_ready && (txq.size() != 0);
`ifdef IO_RX_EN
      rx_ok = rx_valid && (rxq.size() < 8);
`endif
      if (mem_wr) begin
        if (!halt_m && !io) ram_m[idx] = mem_dout;
        else if (!halt_m && (off == 3'd0 || off == 3'd4) && (off == 3'd4 || mem_dout != 8'h00)) begin
          if (txq.size() < 16 || pop_tx) txq.push_back(off == 3'd4 ? 8'h00 : mem_dout);
          else ovf_m = 1;
          if (off == 3'd4) halt_m = 1;
        end
      end else if (!io) begin
        din_known = ram_m.exists(idx);
        if (din_known) exp_din = ram_m[idx];
      end else begin
        din_known = 1;
        case (off)
          3'd0: begin
            exp_din = 8'h00;
`ifdef IO_RX_EN
            if (rxq.size() != 0) exp_din = rxq.pop_front();
`endif
          end
          3'd4: begin
            exp_din = pre[7:0];
            snap_m = pre[31:8];
          end
          3'd5: exp_din = snap_m[7:0];
          3'd6: exp_din = snap_m[15:8];
          3'd7: exp_din = snap_m[23:16];
          default: exp_din = 8'h00;
        endcase
      end
      if (pop_tx) void'(txq.pop_front());
`ifdef IO_RX_EN
      if (rx_ok) rxq.push_back(rx_data);
`endif
    end
  endtask

  // Present one bus cycle, clock it, then check all outputs
  task automatic applyStimulus(input logic [31:0] addr, input logic [7:0] data, input logic wr, input string tag);
    mem_a = addr;
    mem_dout = data;
    mem_wr = wr;
    modelEdge();
    @(posedge clk_in);
    #1;
    checkAll(tag);
  endtask

  function automatic logic [31:0] ioAddr(input logic [2:0] off);
    logic [31:0] a;
    a = $urandom;
    a[17:16] = 2'b11;
    a[2:0] = off;
    return a;
  endfunction

  function automatic logic [31:0] ramAddr();
    logic [31:0] a;
    a = $urandom;
    a[15:6] = 10'h004;
    if (a[17:16] == 2'b11) a[17] = 1'b0;
    return a;
  endfunction

  initial begin
    logic [7:0]  snap_bytes [4];
    logic [31:0] exp_count;
    logic [31:0] waddrs [16];
    logic [2:0]  woff;
    int          op;

    rst_in = 1'b0;
    tx_ready = 1'b1;
    mem_a = 32'h30001;
    mem_dout = 8'h00;
    mem_wr = 1'b0;
    din_known = 0;
`ifdef IO_RX_EN
    rx_valid = 1'b0;
    rx_data = 8'h00;
`endif

    // Reset state
    applyStimulus(32'h30001, 8'h00, 1'b0, "reset0");
    applyStimulus(32'h30001, 8'h00, 1'b0, "reset1");
    checkOutput("reset_mem_din", mem_din, 8'h00);
    checkOutput("reset_tx_valid", tx_valid, 1'b0);
    rst_in = 1'b1;

    // Cycle counter snapshot after ~100 cycles
    for (int i = 0; i < 100 + $urandom_range(0, 20); i++) applyStimulus(32'h30001, 8'h00, 1'b0, "idle");
    exp_count = cyc;
    applyStimulus(32'h30004, 8'h00, 1'b0, "snap_b0");
    snap_bytes[0] = mem_din;
    for (int k = 1; k < 4; k++) begin
      applyStimulus(32'h30004 + k + 32'd0 + 32'd0 + 32'd0 + 32'h0, 8'h00, 1'b0, "snap_bn");
      snap_bytes[k] = mem_din;
    end
    checkOutput("snapshot_value", {snap_bytes[3], snap_bytes[2], snap_bytes[1], snap_bytes[0]}, exp_count);

    // RAM write/read, read-after-write and aliasing
    applyStimulus(32'h00010, 8'hA5, 1'b1, "ram_wr");
    applyStimulus(32'h00010, 8'h00, 1'b0, "ram_raw");
    checkOutput("ram_raw_a5", mem_din, 8'hA5);
    applyStimulus(32'h20010, 8'h00, 1'b0, "ram_alias");
    checkOutput("ram_alias_a5", mem_din, 8'hA5);
    for (int i = 0; i < 16; i++) begin
      waddrs[i] = ramAddr();
      applyStimulus(waddrs[i], 8'($urandom), 1'b1, "ram_rand_wr");
    end
    for (int i = 15; i >= 0; i--) applyStimulus(waddrs[i], 8'h00, 1'b0, "ram_rand_rd");

    // TX FIFO fill with the UART stalled
    tx_ready = 1'b0;
    for (int i = 0; i < 13; i++) applyStimulus(32'h30000, 8'h41, 1'b1, "tx_fill");
    checkOutput("tx_iobf_after13", io_buffer_full, 1'b0);
    applyStimulus(32'h30000, 8'h41, 1'b1, "tx_fill14");
    checkOutput("tx_iobf_after14", io_buffer_full, 1'b1);
    applyStimulus(32'h30000, 8'($urandom_range(1, 255)), 1'b1, "tx_fill15");
    applyStimulus(32'h30000, 8'($urandom_range(1, 255)), 1'b1, "tx_fill16");
    checkOutput("tx_no_ovf_at16", tx_overflow, 1'b0);
    applyStimulus(32'h30000, 8'h42, 1'b1, "tx_push17");
    checkOutput("tx_ovf_at17", tx_overflow, 1'b1);
    applyStimulus(32'h30000, 8'h00, 1'b1, "tx_zero_write");
    tx_ready = 1'b1;
    for (int i = 0; i < 18; i++) applyStimulus(32'h30001, 8'h00, 1'b0, "tx_drain");
    checkOutput("tx_drained", tx_valid, 1'b0);

    // Randomized mix of RAM, I/O and TX traffic
    for (int i = 0; i < 200; i++) begin
      tx_ready = ($urandom_range(0, 3) != 0) ? 1'b0 : 1'b1;
`ifdef IO_RX_EN
      rx_valid = $urandom_range(0, 1);
      rx_data = 8'($urandom);
`endif
      op = $urandom_range(0, 4);
      case (op)
        0: applyStimulus(32'h30000, ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom), 1'b1, "rnd_tx");
        1: applyStimulus(ramAddr(), 8'($urandom), 1'b1, "rnd_ram_wr");
        2: applyStimulus(ramAddr(), 8'h00, 1'b0, "rnd_ram_rd");
        3: applyStimulus(ioAddr(3'($urandom_range(0, 7))), 8'h00, 1'b0, "rnd_io_rd");
        default: begin
          woff = 3'($urandom_range(1, 7));
          if (woff == 3'd4) woff = 3'd3;
          applyStimulus(ioAddr(woff), 8'($urandom), 1'b1, "rnd_io_wr");
        end
      endcase
    end
    tx_ready = 1'b1;
`ifdef IO_RX_EN
    rx_valid = 1'b0;
`endif
    for (int i = 0; i < 20; i++) applyStimulus(32'h30001, 8'h00, 1'b0, "rnd_drain");

`ifdef IO_RX_EN
    // RX FIFO: drain leftovers, then ordered pops and full flag
    for (int i = 0; i < 9; i++) applyStimulus(32'h30000, 8'h00, 1'b0, "rx_flush");
    rx_valid = 1'b1;
    rx_data = 8'h31;
    applyStimulus(32'h30001, 8'h00, 1'b0, "rx_push31");
    rx_data = 8'h32;
    applyStimulus(32'h30001, 8'h00, 1'b0, "rx_push32");
    rx_valid = 1'b0;
    applyStimulus(32'h30000, 8'h00, 1'b0, "rx_pop1");
    checkOutput("rx_pop_31", mem_din, 8'h31);
    applyStimulus(32'h30000, 8'h00, 1'b0, "rx_pop2");
    checkOutput("rx_pop_32", mem_din, 8'h32);
    applyStimulus(32'h30000, 8'h00, 1'b0, "rx_pop3");
    checkOutput("rx_pop_empty", mem_din, 8'h00);
    rx_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rx_data = 8'($urandom);
      applyStimulus(32'h30001, 8'h00, 1'b0, "rx_fill");
    end
    checkOutput("rx_ready_full", rx_ready, 1'b0);
    rx_valid = 1'b0;
    for (int i = 0; i < 8; i++) applyStimulus(32'h30000, 8'h00, 1'b0, "rx_drain");
`endif

    // Reset with 5 bytes queued in TX
    tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) applyStimulus(32'h30000, 8'($urandom_range(1, 255)), 1'b1, "pre_rst_tx");
    rst_in = 1'b0;
    applyStimulus(32'h30001, 8'h00, 1'b0, "mid_reset");
    rst_in = 1'b1;
    checkOutput("rst_tx_valid", tx_valid, 1'b0);
    checkOutput("rst_iobf", io_buffer_full, 1'b0);
    checkOutput("rst_ovf", tx_overflow, 1'b0);
    tx_ready = 1'b1;
    for (int i = 0; i < 3; i++) applyStimulus(32'h30001, 8'h00, 1'b0, "post_rst_idle");
    applyStimulus(32'h30004, 8'h00, 1'b0, "post_rst_counter");
    checkOutput("post_rst_counter_byte", mem_din, 8'd3);
    applyStimulus(32'h00010, 8'h00, 1'b0, "post_rst_ram");
    checkOutput("post_rst_ram_a5", mem_din, 8'hA5);

    // Halt: 0x00 sent, then writes ignored but reads still served
    applyStimulus(32'h00020, 8'h5C, 1'b1, "pre_halt_ram");
    applyStimulus(32'h30004, 8'hFF, 1'b1, "halt_write");
    checkOutput("halt_tx_data", tx_data, 8'h00);
    checkOutput("halt_flag", program_halt, 1'b1);
    applyStimulus(32'h00020, 8'h77, 1'b1, "halt_ram_wr");
    applyStimulus(32'h30000, 8'h55, 1'b1, "halt_tx_wr");
    applyStimulus(32'h00020, 8'h00, 1'b0, "halt_ram_rd");
    checkOutput("halt_ram_kept", mem_din, 8'h5C);
    checkOutput("halt_no_tx", tx_valid, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
